// File: rtl/uc_seq.sv
// uc_seq -- sequencing control unit for the single-cycle microcontroller.
//
// Decodes the 6-bit Opcode (instr[15:10]) into the datapath controls.
// A small FSM adds a timed PC stall (WAIT) and a HALT state. The PC advances
// only when pc_en is high.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   Opcode    instr[15:10]
//   z         registered zero flag
//   wait_cnt  WAIT stall length N (instr[CNT_W-1:0])
//   s_inc     1: PC+1, 0: jump target
//   s_inm     1: immediate path
//   we3       register file write enable
//   wez       zero-flag write enable
//   Op        ALU operation
//   pc_en     PC load enable
//   busy      high in WAIT state
//   halted    high in HALT state
module uc_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic [CNT_W-1:0] wait_cnt,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [1:0] {RUN = 2'd0, WT = 2'd1, HLT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic op_halt, op_wait, wait_go;
  assign op_halt = (Opcode == 6'b000011);
  assign op_wait = (Opcode == 6'b000100);
  // WAIT 0 is a plain NOP and never enters the stall state.
  assign wait_go = op_wait && (wait_cnt != '0);

  // cnt holds the remaining stall cycles, including the current one; the
  // last WT cycle (cnt==1) releases the PC, so WAIT N spans N+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (op_halt) begin
            state <= HLT;
          end else if (wait_go) begin
            state <= WT;
            cnt   <= wait_cnt;
          end
        end
        WT: begin
          if (cnt == CNT_ONE) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HLT: ;
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_en = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          pc_en = 1'b1;
          casez (Opcode)
            6'b1?????: begin
              Op  = Opcode[4:2];
              we3 = 1'b1;
              wez = 1'b1;
            end
            6'b01????: begin
              s_inm = 1'b1;
              we3   = 1'b1;
            end
            6'b000000: s_inc = 1'b0;
            6'b000001: s_inc = ~z;
            6'b000010: s_inc = z;
            6'b000011: pc_en = 1'b0;
            6'b000100: pc_en = ~wait_go;
            default: ;
          endcase
        end
        WT:      pc_en = (cnt == CNT_ONE);
        default: ;
      endcase
    end
  end

  assign busy   = (state == WT);
  assign halted = (state == HLT);

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed cases followed by random opcodes,
// compared every cycle against a queue-based behavioural model.
module tb_uc_seq;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             z;
  logic [CNT_W-1:0] wait_cnt;
  logic             s_inc, s_inm, we3, wez, pc_en, busy, halted;
  logic [2:0]       Op;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_halt marks the halted state; stall_q holds the pc_en value of
  // each remaining stall cycle (a non-empty queue means the unit is busy).
  bit m_halt = 1'b0;
  bit stall_q[$];

  uc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .wait_cnt(wait_cnt),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
  task automatic cyc(input logic r, input logic [5:0] op, input logic zz,
                     input logic [CNT_W-1:0] wc);
    bit e_inc, e_inm, e_we3, e_wez, e_pc;
    logic [2:0] e_op;
    reset = r; Opcode = op; z = zz; wait_cnt = wc;
    @(negedge clk);
    e_inc = 1; e_inm = 0; e_we3 = 0; e_wez = 0; e_op = 0; e_pc = 0;
    if (r || m_halt) begin
      e_pc = 0;
    end else if (stall_q.size() > 0) begin
      e_pc = stall_q[0];
    end else begin
      e_pc = 1;
      if (op[5]) begin
        e_op = op[4:2]; e_we3 = 1; e_wez = 1;
      end else if (op[4]) begin
        e_inm = 1; e_we3 = 1;
      end else if (op == 6'd0) e_inc = 0;
      else if (op == 6'd1) e_inc = !zz;
      else if (op == 6'd2) e_inc = zz;
      else if (op == 6'd3) e_pc = 0;
      else if (op == 6'd4) e_pc = (wc == 0);
    end
    chk("s_inc",  s_inc,  e_inc);
    chk("s_inm",  s_inm,  e_inm);
    chk("we3",    we3,    e_we3);
    chk("wez",    wez,    e_wez);
    chk("Op",     Op,     e_op);
    chk("pc_en",  pc_en,  e_pc);
    chk("busy",   busy,   stall_q.size() > 0);
    chk("halted", halted, m_halt);
    chk("excl",   busy & halted, 0);
    if (r) begin
      stall_q.delete();
      m_halt = 0;
    end else if (!m_halt) begin
      if (stall_q.size() > 0) void'(stall_q.pop_front());
      else if (op == 6'd3) m_halt = 1;
      else if (op == 6'd4 && wc != 0) begin
        for (int i = 1; i < int'(wc); i++) stall_q.push_back(1'b0);
        stall_q.push_back(1'b1);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; Opcode = 6'b100000; z = 0; wait_cnt = 0;
    @(posedge clk); #1;
    // reset pulse with an ALU opcode, then first normal cycle
    cyc(1, 6'b100000, 0, 0);
    cyc(1, 6'b100000, 0, 0);
    cyc(0, 6'b100000, 0, 0);
    // ALU, LI, branches
    cyc(0, 6'b110100, 0, 0);
    cyc(0, 6'b010000, 1, 0);
    cyc(0, 6'b000001, 1, 0);
    cyc(0, 6'b000001, 0, 0);
    cyc(0, 6'b000010, 0, 0);
    cyc(0, 6'b000000, 1, 0);
    cyc(0, 6'b000000, 0, 0);
    // WAIT 3 with opcodes during the stall, then WAIT 0
    cyc(0, 6'b000100, 0, 8'd3);
    for (int i = 0; i < 3; i++) cyc(0, 6'b111100, 1, 8'd5);
    cyc(0, 6'b000100, 0, 8'd0);
    cyc(0, 6'b001000, 0, 8'd0);
    // HALT held with ALU opcodes, then reset
    cyc(0, 6'b000011, 0, 0);
    for (int i = 0; i < 22; i++) cyc(0, 6'b100000 | 6'(i), i[0], 8'd4);
    cyc(1, 6'b100000, 0, 0);
    cyc(0, 6'b100000, 0, 0);
    // reset in the 2nd cycle of a long WAIT
    cyc(0, 6'b000100, 0, 8'd200);
    cyc(1, 6'b000000, 0, 0);
    cyc(0, 6'b101000, 0, 0);
    // maximum WAIT: 256 cycles total
    cyc(0, 6'b000100, 0, 8'd255);
    for (int i = 0; i < 255; i++) cyc(0, 6'b000100, 0, 8'd255);
    cyc(0, 6'b100000, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      logic [CNT_W-1:0] wc;
      op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 4));
      wc = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 6));
      cyc($urandom_range(0, 39) == 0, op, 1'($urandom), wc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
